regfile_wb_queue: RTL and testbench

Write-back queue that drives the write port of the 32 x 32-bit MIPS register file (`Write_reg`, `Data`, `RegWrite`), acting as its single writer. It accepts results from the ALU and from the memory/load path through valid/ready handshakes and buffers them in a small in-order FIFO. It retires one entry per clock into the register file. It also provides forwarding lookups so decode can see values that are queued but not yet written.

---
 rtl/regfile_wb_queue_if.sv | 57 +++++
 rtl/regfile_wb_queue.sv | 112 +++++++++++
 tb/tb_regfile_wb_queue.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_if.sv
// rtl/regfile_wb_queue_if.sv - result handshakes, register-file write port and forwarding lookups
interface regfile_wb_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              alu_valid;
  logic [4:0]        alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [4:0]        mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              wb_hold;

  logic [4:0]        Write_reg;
  logic [DATA_W-1:0] Data;
  logic              RegWrite;

  logic [4:0]        fwd_reg1;
  logic [4:0]        fwd_reg2;
  logic              fwd_hit1;
  logic              fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;

  logic [31:0]       pending;
  logic [CW-1:0]     count;

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    output alu_ready,
    input  mem_valid, mem_reg, mem_data,
    output mem_ready,
    input  wb_hold,
    output Write_reg, Data, RegWrite,
    input  fwd_reg1, fwd_reg2,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
    output pending, count
  );

  modport master (
    output alu_valid, alu_reg, alu_data,
    input  alu_ready,
    output mem_valid, mem_reg, mem_data,
    input  mem_ready,
    output wb_hold,
    input  Write_reg, Data, RegWrite,
    output fwd_reg1, fwd_reg2,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
    input  pending, count
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order write-back FIFO feeding the register file write port
// Load results win arbitration; lookups return the youngest queued value for a register.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;

  logic [4:0]        ent_reg  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  ptr_t              head;
  ptr_t              tail;
  logic [CW-1:0]     occ;

  logic              not_full;
  logic              take_mem;
  logic              take_alu;
  logic              push;
  logic              pop;
  logic [4:0]        in_reg;
  logic [DATA_W-1:0] in_data;

  // Readies look only at occupancy and mem_valid, never at alu_valid.
  always_comb begin
    not_full = (occ < CW'(DEPTH));
    take_mem = bus.mem_valid && not_full;
    take_alu = bus.alu_valid && not_full && !bus.mem_valid;
    in_reg   = take_mem ? bus.mem_reg  : bus.alu_reg;
    in_data  = take_mem ? bus.mem_data : bus.alu_data;
    push     = (take_mem || take_alu) && (in_reg != 5'd0);
    pop      = (occ != '0) && !bus.wb_hold;
  end

  assign bus.mem_ready = not_full;
  assign bus.alu_ready = not_full && !bus.mem_valid;
  assign bus.RegWrite  = pop;
  assign bus.Write_reg = (occ != '0) ? ent_reg[head]  : 5'd0;
  assign bus.Data      = (occ != '0) ? ent_data[head] : '0;
  assign bus.count     = occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ent_reg[tail]  <= in_reg;
      ent_data[tail] <= in_data;
    end
  end

  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [31:0]       pend;
  ptr_t              idx;

  // Walk oldest to youngest so later matches overwrite earlier ones.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    data1 = '0;
    data2 = '0;
    pend  = '0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + ptr_t'(i);
      if (CW'(i) < occ) begin
        pend[ent_reg[idx]] = 1'b1;
        if ((bus.fwd_reg1 != 5'd0) && (ent_reg[idx] == bus.fwd_reg1)) begin
          hit1  = 1'b1;
          data1 = ent_data[idx];
        end
        if ((bus.fwd_reg2 != 5'd0) && (ent_reg[idx] == bus.fwd_reg2)) begin
          hit2  = 1'b1;
          data2 = ent_data[idx];
        end
      end
    end
  end

  assign bus.fwd_hit1  = hit1;
  assign bus.fwd_hit2  = hit2;
  assign bus.fwd_data1 = data1;
  assign bus.fwd_data2 = data2;
  assign bus.pending   = pend;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - vector table, corner sequences and randomized model check
module tb_regfile_wb_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  regfile_wb_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] av, ar, ad, mv, mr, md, hold, f1;
    logic [31:0] e_ar, e_mr, e_rw, e_wr, e_d, e_cnt, e_h1, e_f1, e_pend;
  } vec_t;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  vec_t vt[14];
  ent_t mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic hold, input logic [4:0] f1, input logic [4:0] f2);
    bus.alu_valid = av;
    bus.alu_reg   = ar;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_reg   = mr;
    bus.mem_data  = md;
    bus.wb_hold   = hold;
    bus.fwd_reg1  = f1;
    bus.fwd_reg2  = f2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] lookup(input logic [4:0] r);
    logic [32:0] res;
    res = '0;
    if (r != 5'd0) begin
      foreach (mq[k]) begin
        if (mq[k].r == r) res = {1'b1, mq[k].d};
      end
    end
    return res;
  endfunction

  initial begin
    logic [32:0] l1, l2;
    logic [31:0] pend;
    logic        av, mv, hold, full, rw;
    logic [4:0]  ar, mr, f1, f2;
    logic [31:0] ad, md;

    vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 8,           1, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 8, 32'hDEADBEEF, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 8,           1, 1, 1, 8, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 32'h100};
    vt[3]  = '{0, 0, 0, 0, 0, 0, 0, 8,           1, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[4]  = '{1, 9, 9, 1, 10, 10, 0, 0,         0, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[5]  = '{1, 9, 9, 0, 0, 0, 0, 10,          1, 1, 1, 10, 10, 1, 1, 10, 32'h400};
    vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 9,           1, 1, 1, 9, 9, 1, 1, 9, 32'h200};
    vt[7]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 0,           1, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[9]  = '{1, 5, 32'h11, 0, 0, 0, 1, 5,      1, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[10] = '{1, 5, 32'h22, 0, 0, 0, 1, 5,      1, 1, 0, 5, 32'h11, 1, 1, 32'h11, 32'h20};
    vt[11] = '{0, 0, 0, 0, 0, 0, 0, 5,           1, 1, 1, 5, 32'h11, 2, 1, 32'h22, 32'h20};
    vt[12] = '{0, 0, 0, 0, 0, 0, 0, 5,           1, 1, 1, 5, 32'h22, 1, 1, 32'h22, 32'h20};
    vt[13] = '{0, 0, 0, 0, 0, 0, 0, 5,           1, 1, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    foreach (vt[n]) begin
      drive(vt[n].av[0], vt[n].ar[4:0], vt[n].ad, vt[n].mv[0], vt[n].mr[4:0], vt[n].md,
            vt[n].hold[0], vt[n].f1[4:0], 5'd0);
      #1;
      chk($sformatf("v%0d alu_ready", n), 32'(bus.alu_ready), vt[n].e_ar);
      chk($sformatf("v%0d mem_ready", n), 32'(bus.mem_ready), vt[n].e_mr);
      chk($sformatf("v%0d RegWrite", n),  32'(bus.RegWrite),  vt[n].e_rw);
      chk($sformatf("v%0d Write_reg", n), 32'(bus.Write_reg), vt[n].e_wr);
      chk($sformatf("v%0d Data", n),      bus.Data,           vt[n].e_d);
      chk($sformatf("v%0d count", n),     32'(bus.count),     vt[n].e_cnt);
      chk($sformatf("v%0d fwd_hit1", n),  32'(bus.fwd_hit1),  vt[n].e_h1);
      chk($sformatf("v%0d fwd_data1", n), bus.fwd_data1,      vt[n].e_f1);
      chk($sformatf("v%0d pending", n),   bus.pending,        vt[n].e_pend);
      tick();
    end

    for (int i = 0; i < 6; i++) begin
      drive(1, 5'(i + 1), 32'h100 + 32'(i), 0, 0, 0, 1, 0, 0);
      #1;
      chk($sformatf("hold push%0d alu_ready", i), 32'(bus.alu_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("full count",     32'(bus.count),     32'd4);
    chk("full alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("full mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("full RegWrite",  32'(bus.RegWrite),  32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("drain%0d RegWrite", i),  32'(bus.RegWrite),  32'd1);
      chk($sformatf("drain%0d Write_reg", i), 32'(bus.Write_reg), 32'(i + 1));
      chk($sformatf("drain%0d Data", i),      bus.Data,           32'h100 + 32'(i));
      tick();
    end
    #1;
    chk("drained count", 32'(bus.count), 32'd0);

    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(11 + i), 32'hA0 + 32'(i), 0, 0, 0, 1, 0, 0);
      tick();
    end
    drive(1, 5'd14, 32'hEE, 0, 0, 0, 1, 0, 0);
    rst = 1'b1;
    #1;
    chk("pre-reset count", 32'(bus.count), 32'd3);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 14, 11);
    #1;
    chk("post-reset count",     32'(bus.count),     32'd0);
    chk("post-reset pending",   bus.pending,        32'd0);
    chk("post-reset Write_reg", 32'(bus.Write_reg), 32'd0);
    chk("post-reset fwd_hit1",  32'(bus.fwd_hit1),  32'd0);
    chk("post-reset alu_ready", 32'(bus.alu_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post-reset%0d RegWrite", i), 32'(bus.RegWrite), 32'd0);
      tick();
    end

    mq.delete();
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 59) == 0);
      av   = 1'($urandom_range(0, 1));
      mv   = ($urandom_range(0, 2) == 0);
      hold = ($urandom_range(0, 3) == 0);
      ar   = 5'($urandom_range(0, 7));
      mr   = 5'($urandom_range(0, 7));
      ad   = $urandom;
      md   = $urandom;
      f1   = 5'($urandom_range(0, 7));
      f2   = 5'($urandom_range(0, 7));
      drive(av, ar, ad, mv, mr, md, hold, f1, f2);
      #1;
      full = (mq.size() >= DEPTH);
      rw   = (mq.size() != 0) && !hold;
      l1   = lookup(f1);
      l2   = lookup(f2);
      pend = '0;
      foreach (mq[k]) pend[mq[k].r] = 1'b1;
      chk($sformatf("rnd%0d count", c),     32'(bus.count),     32'(mq.size()));
      chk($sformatf("rnd%0d mem_ready", c), 32'(bus.mem_ready), 32'(!full));
      chk($sformatf("rnd%0d alu_ready", c), 32'(bus.alu_ready), 32'(!full && !mv));
      chk($sformatf("rnd%0d RegWrite", c),  32'(bus.RegWrite),  32'(rw));
      chk($sformatf("rnd%0d Write_reg", c), 32'(bus.Write_reg), (mq.size() != 0) ? 32'(mq[0].r) : 32'd0);
      chk($sformatf("rnd%0d Data", c),      bus.Data,           (mq.size() != 0) ? mq[0].d : 32'd0);
      chk($sformatf("rnd%0d fwd_hit1", c),  32'(bus.fwd_hit1),  32'(l1[32]));
      chk($sformatf("rnd%0d fwd_data1", c), bus.fwd_data1,      l1[31:0]);
      chk($sformatf("rnd%0d fwd_hit2", c),  32'(bus.fwd_hit2),  32'(l2[32]));
      chk($sformatf("rnd%0d fwd_data2", c), bus.fwd_data2,      l2[31:0]);
      chk($sformatf("rnd%0d pending", c),   bus.pending,        pend);
      tick();
      if (rst) begin
        mq.delete();
      end else begin
        if (rw) void'(mq.pop_front());
        if (!full) begin
          if (mv && mr != 5'd0)       mq.push_back('{r: mr, d: md});
          else if (!mv && av && ar != 5'd0) mq.push_back('{r: ar, d: ad});
        end
      end
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
